// File: rtl/tick_scheduler.sv
// tick_scheduler
//   Shared-prescaler tick scheduler. A single prescaler divides i_CLK into a
//   base tick. N_CH channels each count base ticks down from a programmable
//   period and emit a one-cycle tick pulse plus a square wave that toggles on
//   every tick. Channels are (re)programmed at runtime over a valid/ready port.
//
// Parameters
//   N_CH     : number of channels (>=1)
//   PRESCALE : i_CLK cycles per base tick (>=1)
//   PW       : period register width, in base ticks
//   CW       : channel index width
//
// Ports
//   i_CLK        : system clock, rising edge
//   i_RST_N      : asynchronous active-low reset
//   i_cfg_valid  : config request
//   o_cfg_ready  : config port can accept (low during the apply cycle)
//   i_cfg_ch     : target channel (out-of-range writes are accepted and dropped)
//   i_cfg_period : channel period in base ticks (0 = idle)
//   i_cfg_en     : channel enable (0 also clears the channel's wave)
//   o_base_tick  : one-cycle pulse every PRESCALE cycles
//   o_tick       : per-channel one-cycle tick pulse
//   o_wave       : per-channel square wave
module tick_scheduler #(
    parameter int unsigned N_CH     = 3,
    parameter int unsigned PRESCALE = 100_000,
    parameter int unsigned PW       = 16,
    parameter int unsigned CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            i_CLK,
    input  logic            i_RST_N,
    input  logic            i_cfg_valid,
    output logic            o_cfg_ready,
    input  logic [CW-1:0]   i_cfg_ch,
    input  logic [PW-1:0]   i_cfg_period,
    input  logic            i_cfg_en,
    output logic            o_base_tick,
    output logic [N_CH-1:0] o_tick,
    output logic [N_CH-1:0] o_wave
);

    localparam int unsigned    PSW    = $clog2(PRESCALE + 1);
    localparam logic [PSW-1:0] P_LAST = PSW'(PRESCALE - 1);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PSW-1:0] p;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            p           <= '0;
            o_base_tick <= 1'b0;
        end else begin
            p           <= (p == P_LAST) ? '0 : p + PSW'(1);
            o_base_tick <= (p == P_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Config FSM: IDLE accepts a request, APPLY writes it one cycle later
    // ------------------------------------------------------------------
    typedef enum logic {
        S_IDLE,
        S_APPLY
    } cfg_state_e;

    cfg_state_e    state;
    logic [CW-1:0] cfg_ch_q;
    logic [PW-1:0] cfg_period_q;
    logic          cfg_en_q;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state        <= S_IDLE;
            o_cfg_ready  <= 1'b1;
            cfg_ch_q     <= '0;
            cfg_period_q <= '0;
            cfg_en_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_cfg_valid) begin
                        cfg_ch_q     <= i_cfg_ch;
                        cfg_period_q <= i_cfg_period;
                        cfg_en_q     <= i_cfg_en;
                        state        <= S_APPLY;
                        o_cfg_ready  <= 1'b0;
                    end
                end
                S_APPLY: begin
                    state       <= S_IDLE;
                    o_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    // One-hot channel select for the apply cycle; an out-of-range index
    // matches no channel, so the write is silently dropped.
    logic [N_CH-1:0] apply_hit;
    logic [PW-1:0]   apply_cnt;

    always_comb begin
        apply_hit = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            apply_hit[i] = (state == S_APPLY) && (32'(cfg_ch_q) == i);
        end
    end

    assign apply_cnt = (cfg_period_q == '0) ? '0 : cfg_period_q - PW'(1);

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    logic [PW-1:0] period [N_CH];
    logic [PW-1:0] cnt    [N_CH];
    logic          en     [N_CH];

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
                en[i]     <= 1'b0;
            end
            o_tick <= '0;
            o_wave <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                o_tick[i] <= 1'b0;
                // A config write takes priority over a coincident base-tick
                // update: the channel restarts and emits no tick this cycle.
                if (apply_hit[i]) begin
                    period[i] <= cfg_period_q;
                    en[i]     <= cfg_en_q;
                    cnt[i]    <= apply_cnt;
                    if (!cfg_en_q) begin
                        o_wave[i] <= 1'b0;
                    end
                end else if (o_base_tick && en[i] && (period[i] != '0)) begin
                    if (cnt[i] == '0) begin
                        o_tick[i] <= 1'b1;
                        o_wave[i] <= ~o_wave[i];
                        cnt[i]    <= period[i] - PW'(1);
                    end else begin
                        cnt[i] <= cnt[i] - PW'(1);
                    end
                end
            end
        end
    end

endmodule
